// File: rtl/cv32e40p_apu_resp_buffer.sv
// APU response buffer: credit-limited issue towards an FPU that cannot be stalled,
// with a tagged result FIFO so the core's writeback can stall, plus flush/drain handling.
module cv32e40p_apu_resp_buffer #(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 5,
  parameter int DATA_W  = 32,
  parameter int FLAGS_W = 5
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               core_req_i,
  input  logic [TAG_W-1:0]   core_tag_i,
  output logic               core_gnt_o,
  output logic               fpu_req_o,
  output logic [TAG_W-1:0]   fpu_tag_o,
  input  logic               fpu_gnt_i,
  input  logic               fpu_rvalid_i,
  input  logic [TAG_W-1:0]   fpu_rtag_i,
  input  logic [DATA_W-1:0]  fpu_rdata_i,
  input  logic [FLAGS_W-1:0] fpu_rflags_i,
  output logic               core_rvalid_o,
  output logic [TAG_W-1:0]   core_rtag_o,
  output logic [DATA_W-1:0]  core_rdata_o,
  output logic [FLAGS_W-1:0] core_rflags_o,
  input  logic               core_rready_i,
  input  logic               flush_i,
  output logic               busy_o,
  output logic               proto_err_o
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ENT_W = TAG_W + DATA_W + FLAGS_W;

  // Handshakes: core_gnt_o is combinational from core_req_i/fpu_gnt_i; a result is
  // taken when core_rvalid_o & core_rready_i; fpu_rvalid_i is a one-cycle pulse
  // that must be captured because the FPU cannot be back-pressured.
  typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [ENT_W-1:0] mem_d [DEPTH];
  logic             proto_err_q, proto_err_d;

  logic [CNT_W:0] outstanding;
  logic           credit_ok, issue, ret, push, pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Credits come from registered counters only, so a pop frees its slot one cycle later.
  assign outstanding = {1'b0, inflight_q} + {1'b0, fifo_cnt_q};
  assign credit_ok   = outstanding < (CNT_W + 1)'(DEPTH);

  assign fpu_req_o  = ~rst_i & (state_q == RUN) & core_req_i & credit_ok & ~flush_i;
  assign fpu_tag_o  = core_tag_i;
  assign core_gnt_o = fpu_req_o & fpu_gnt_i;
  assign issue      = core_req_i & core_gnt_o;

  assign ret  = fpu_rvalid_i & (inflight_q != '0);
  assign push = ret & (state_q == RUN) & ~flush_i;

  assign core_rvalid_o = (fifo_cnt_q != '0);
  assign pop           = core_rvalid_o & core_rready_i;
  assign {core_rtag_o, core_rdata_o, core_rflags_o} = mem_q[rd_ptr_q];

  assign busy_o      = (inflight_q != '0) | (fifo_cnt_q != '0) | (state_q == DRAIN);
  assign proto_err_o = proto_err_q;

  always_comb begin
    inflight_d  = inflight_q;
    fifo_cnt_d  = fifo_cnt_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    mem_d       = mem_q;
    state_d     = state_q;
    proto_err_d = proto_err_q | (fpu_rvalid_i & (inflight_q == '0));

    case ({issue, ret})
      2'b10:   inflight_d = inflight_q + CNT_W'(1);
      2'b01:   inflight_d = inflight_q - CNT_W'(1);
      default: inflight_d = inflight_q;
    endcase

    if (push) begin
      mem_d[wr_ptr_q] = {fpu_rtag_i, fpu_rdata_i, fpu_rflags_i};
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase

    // Flush empties the FIFO; stay in DRAIN until every in-flight result has come back.
    if (flush_i) begin
      fifo_cnt_d = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      state_d    = (inflight_d != '0) ? DRAIN : RUN;
    end else if ((state_q == DRAIN) && (inflight_d == '0)) begin
      state_d = RUN;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= RUN;
      inflight_q  <= '0;
      fifo_cnt_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      inflight_q  <= inflight_d;
      fifo_cnt_q  <= fifo_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      proto_err_q <= proto_err_d;
    end
  end

  // Result storage carries no reset; validity is tracked by fifo_cnt_q.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_cv32e40p_apu_resp_buffer.sv
// Bench for cv32e40p_apu_resp_buffer: request-path vector table, scripted corner
// sequences and a result scoreboard fed by a small fixed-latency FPU model.
module tb_cv32e40p_apu_resp_buffer;
  localparam int DEPTH   = 4;
  localparam int TAG_W   = 5;
  localparam int DATA_W  = 32;
  localparam int FLAGS_W = 5;
  localparam int EXP_W   = TAG_W + DATA_W + FLAGS_W;

  // clock / reset / signals
  logic               clk = 1'b0;
  logic               rst_i = 1'b1;
  logic               core_req_i = 1'b0;
  logic [TAG_W-1:0]   core_tag_i = '0;
  logic               core_gnt_o;
  logic               fpu_req_o;
  logic [TAG_W-1:0]   fpu_tag_o;
  logic               fpu_gnt_i = 1'b0;
  logic               fpu_rvalid_i = 1'b0;
  logic [TAG_W-1:0]   fpu_rtag_i = '0;
  logic [DATA_W-1:0]  fpu_rdata_i = '0;
  logic [FLAGS_W-1:0] fpu_rflags_i = '0;
  logic               core_rvalid_o;
  logic [TAG_W-1:0]   core_rtag_o;
  logic [DATA_W-1:0]  core_rdata_o;
  logic [FLAGS_W-1:0] core_rflags_o;
  logic               core_rready_i = 1'b0;
  logic               flush_i = 1'b0;
  logic               busy_o;
  logic               proto_err_o;

  always #5 clk = ~clk;

  cv32e40p_apu_resp_buffer #(
    .DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W), .FLAGS_W(FLAGS_W)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .core_req_i(core_req_i), .core_tag_i(core_tag_i), .core_gnt_o(core_gnt_o),
    .fpu_req_o(fpu_req_o), .fpu_tag_o(fpu_tag_o), .fpu_gnt_i(fpu_gnt_i),
    .fpu_rvalid_i(fpu_rvalid_i), .fpu_rtag_i(fpu_rtag_i), .fpu_rdata_i(fpu_rdata_i),
    .fpu_rflags_i(fpu_rflags_i),
    .core_rvalid_o(core_rvalid_o), .core_rtag_o(core_rtag_o), .core_rdata_o(core_rdata_o),
    .core_rflags_o(core_rflags_o), .core_rready_i(core_rready_i),
    .flush_i(flush_i), .busy_o(busy_o), .proto_err_o(proto_err_o)
  );

  // scoreboard state
  logic [EXP_W-1:0] exp_q[$];
  typedef struct {int due; logic [TAG_W-1:0] tag;} pend_t;
  pend_t pend_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  int    n_popped = 0;
  int    cyc      = 0;
  int    lat      = 2;
  logic  auto_fpu = 1'b0;

  typedef struct {
    logic req; logic fgnt; logic flush; logic rst;
    logic exp_freq; logic exp_gnt; logic exp_busy;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // One clock: sample/score at negedge, then advance and drive the FPU model.
  task automatic tick();
    pend_t p;
    @(negedge clk);
    if (core_rvalid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("spurious_rvalid", 64'(core_rvalid_o), 64'(0));
      end else begin
        chk("rresult", 64'({core_rtag_o, core_rdata_o, core_rflags_o}), 64'(exp_q[0]));
        if (core_rready_i) begin
          void'(exp_q.pop_front());
          n_popped++;
        end
      end
    end
    if (auto_fpu && core_gnt_o) begin
      p.due = cyc + lat;
      p.tag = core_tag_i;
      pend_q.push_back(p);
    end
    @(posedge clk);
    cyc++;
    #1;
    fpu_rvalid_i = 1'b0;
    if (auto_fpu && pend_q.size() > 0 && pend_q[0].due == cyc) begin
      p = pend_q.pop_front();
      fpu_rvalid_i = 1'b1;
      fpu_rtag_i   = p.tag;
      fpu_rdata_i  = $urandom;
      fpu_rflags_i = FLAGS_W'($urandom_range(0, 31));
      exp_q.push_back({fpu_rtag_i, fpu_rdata_i, fpu_rflags_i});
    end
  endtask

  task automatic ret_now(input logic [TAG_W-1:0] tag, input logic keep);
    fpu_rvalid_i = 1'b1;
    fpu_rtag_i   = tag;
    fpu_rdata_i  = $urandom;
    fpu_rflags_i = FLAGS_W'($urandom_range(0, 31));
    if (keep) exp_q.push_back({fpu_rtag_i, fpu_rdata_i, fpu_rflags_i});
  endtask

  task automatic do_reset();
    core_req_i = 1'b0; fpu_gnt_i = 1'b0; core_rready_i = 1'b0; flush_i = 1'b0;
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    exp_q.delete();
    pend_q.delete();
    fpu_rvalid_i = 1'b0;
  endtask

  task automatic wait_drain();
    logic done = 1'b0;
    core_req_i = 1'b0;
    core_rready_i = 1'b1;
    for (int i = 0; i < 60 && !done; i++) begin
      tick();
      if (exp_q.size() == 0 && pend_q.size() == 0 && !busy_o) done = 1'b1;
    end
    chk("drain_done", 64'(done), 64'(1));
    core_rready_i = 1'b0;
  endtask

  initial begin
    //               req fgnt flush rst  freq gnt busy_next
    vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    // reset state
    do_reset();
    #1;
    chk("rst_rvalid", 64'(core_rvalid_o), 64'(0));
    chk("rst_busy", 64'(busy_o), 64'(0));
    chk("rst_proto", 64'(proto_err_o), 64'(0));
    chk("rst_gnt", 64'(core_gnt_o), 64'(0));

    // request-path vector table
    foreach (vecs[i]) begin
      do_reset();
      core_req_i = vecs[i].req; fpu_gnt_i = vecs[i].fgnt;
      flush_i = vecs[i].flush; rst_i = vecs[i].rst;
      core_tag_i = TAG_W'(i + 3);
      #1;
      chk($sformatf("vec%0d_fpu_req", i), 64'(fpu_req_o), 64'(vecs[i].exp_freq));
      chk($sformatf("vec%0d_gnt", i), 64'(core_gnt_o), 64'(vecs[i].exp_gnt));
      chk($sformatf("vec%0d_fpu_tag", i), 64'(fpu_tag_o), 64'(i + 3));
      tick();
      core_req_i = 1'b0; flush_i = 1'b0; rst_i = 1'b0;
      #1;
      chk($sformatf("vec%0d_busy", i), 64'(busy_o), 64'(vecs[i].exp_busy));
    end

    // back-to-back issue, latency 2, core always ready
    do_reset();
    auto_fpu = 1'b1; lat = 2; core_rready_i = 1'b1; n_popped = 0;
    for (int t = 1; t <= 5; t++) begin
      core_req_i = 1'b1; fpu_gnt_i = 1'b1; core_tag_i = TAG_W'(t);
      #1;
      chk("b2b_gnt", 64'(core_gnt_o), 64'(1));
      if (t == 3) chk("b2b_no_bypass", 64'(core_rvalid_o), 64'(0));
      if (t == 4) begin
        chk("b2b_first_valid", 64'(core_rvalid_o), 64'(1));
        chk("b2b_first_tag", 64'(core_rtag_o), 64'(1));
      end
      tick();
    end
    wait_drain();
    chk("b2b_count", 64'(n_popped), 64'(5));

    // credit stall with four buffered results
    do_reset();
    auto_fpu = 1'b1; lat = 2; core_rready_i = 1'b0;
    for (int t = 1; t <= 4; t++) begin
      core_req_i = 1'b1; fpu_gnt_i = 1'b1; core_tag_i = TAG_W'(t);
      tick();
    end
    core_req_i = 1'b0;
    repeat (3) tick();
    core_req_i = 1'b1; core_tag_i = TAG_W'(5);
    #1;
    chk("stall_head_tag", 64'(core_rtag_o), 64'(1));
    chk("stall_gnt", 64'(core_gnt_o), 64'(0));
    tick();
    core_rready_i = 1'b1;
    #1;
    chk("stall_pop_cycle_gnt", 64'(core_gnt_o), 64'(0));
    tick();
    core_rready_i = 1'b0;
    #1;
    chk("stall_next_cycle_gnt", 64'(core_gnt_o), 64'(1));
    tick();
    wait_drain();

    // issue and return coincide with three in flight
    do_reset();
    auto_fpu = 1'b0; core_rready_i = 1'b0; fpu_gnt_i = 1'b1;
    for (int t = 1; t <= 3; t++) begin
      core_req_i = 1'b1; core_tag_i = TAG_W'(t);
      tick();
    end
    core_tag_i = TAG_W'(4);
    ret_now(1, 1'b1);
    #1;
    chk("coin_gnt", 64'(core_gnt_o), 64'(1));
    tick();
    core_req_i = 1'b0;
    #1;
    chk("coin_inflight", 64'(dut.inflight_q), 64'(3));
    chk("coin_fifo_cnt", 64'(dut.fifo_cnt_q), 64'(1));
    for (int t = 2; t <= 4; t++) begin
      ret_now(TAG_W'(t), 1'b1);
      tick();
    end
    wait_drain();

    // flush with two buffered and two in flight
    do_reset();
    auto_fpu = 1'b0; core_rready_i = 1'b0; fpu_gnt_i = 1'b1;
    for (int t = 1; t <= 4; t++) begin
      core_req_i = 1'b1; core_tag_i = TAG_W'(t);
      tick();
    end
    core_req_i = 1'b0;
    ret_now(1, 1'b1); tick();
    ret_now(2, 1'b1); tick();
    tick();
    flush_i = 1'b1; core_req_i = 1'b1; core_tag_i = TAG_W'(9);
    #1;
    chk("flush_no_gnt", 64'(core_gnt_o), 64'(0));
    chk("flush_no_fpu_req", 64'(fpu_req_o), 64'(0));
    tick();
    flush_i = 1'b0; exp_q.delete(); core_tag_i = TAG_W'(7);
    #1;
    chk("flush_rvalid", 64'(core_rvalid_o), 64'(0));
    chk("flush_state", 64'(dut.state_q), 64'(1));
    chk("flush_busy", 64'(busy_o), 64'(1));
    chk("drain_gnt", 64'(core_gnt_o), 64'(0));
    ret_now(3, 1'b0);
    tick();
    chk("drain_drop3", 64'(core_rvalid_o), 64'(0));
    chk("drain_gnt2", 64'(core_gnt_o), 64'(0));
    ret_now(4, 1'b0);
    tick();
    #1;
    chk("drain_drop4", 64'(core_rvalid_o), 64'(0));
    chk("flush_regrant", 64'(core_gnt_o), 64'(1));
    chk("flush_run_state", 64'(dut.state_q), 64'(0));
    tick();
    core_req_i = 1'b0;
    ret_now(7, 1'b1);
    tick();
    #1;
    chk("flush_new_valid", 64'(core_rvalid_o), 64'(1));
    chk("flush_new_tag", 64'(core_rtag_o), 64'(7));
    wait_drain();

    // spurious return while idle
    do_reset();
    ret_now(3, 1'b0);
    tick();
    #1;
    chk("spur_proto", 64'(proto_err_o), 64'(1));
    chk("spur_rvalid", 64'(core_rvalid_o), 64'(0));
    chk("spur_busy", 64'(busy_o), 64'(0));
    repeat (3) tick();
    chk("spur_sticky", 64'(proto_err_o), 64'(1));
    do_reset();
    #1;
    chk("spur_cleared", 64'(proto_err_o), 64'(0));

    // reset with three in flight
    do_reset();
    fpu_gnt_i = 1'b1;
    for (int t = 1; t <= 3; t++) begin
      core_req_i = 1'b1; core_tag_i = TAG_W'(t);
      tick();
    end
    rst_i = 1'b1;
    #1;
    chk("rst_hold_gnt", 64'(core_gnt_o), 64'(0));
    chk("rst_hold_fpu_req", 64'(fpu_req_o), 64'(0));
    tick();
    rst_i = 1'b0; exp_q.delete();
    #1;
    chk("rst3_rvalid", 64'(core_rvalid_o), 64'(0));
    chk("rst3_busy", 64'(busy_o), 64'(0));
    chk("rst3_gnt", 64'(core_gnt_o), 64'(1));
    tick();
    core_req_i = 1'b0;

    // random traffic through the fixed-latency FPU model
    do_reset();
    auto_fpu = 1'b1; lat = $urandom_range(1, 4);
    for (int i = 0; i < 80; i++) begin
      core_req_i    = 1'($urandom_range(0, 1));
      fpu_gnt_i     = ($urandom_range(0, 3) != 0);
      core_tag_i    = TAG_W'($urandom_range(0, 31));
      core_rready_i = 1'($urandom_range(0, 1));
      tick();
    end
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
